// File: rtl/pipeline_hazard_unit.sv
// Interlock and forwarding controller for the segmented pipeline.
// Tracks destination tags of in-flight instructions (stage 0 = EX) and
// produces load-use stall, branch flush and registered forwarding selects.
module pipeline_hazard_unit #(
  parameter int RA_W       = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 1,
  parameter int BR_PENALTY = 2,
  parameter int CNT_W      = 16,
  parameter int FWD_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr,
  input  logic [RA_W-1:0]  id_dest,
  input  logic             id_load,
  input  logic             br_taken,
  output logic             stall,
  output logic             flush,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned UD    = DEPTH;
  localparam int unsigned ULAT  = LOAD_LAT;
  localparam int unsigned FC_W  = (BR_PENALTY > 1) ? $clog2(BR_PENALTY) : 1;
  localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(BR_PENALTY - 1);

  // Tag pipeline entries
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_wr;
  logic [DEPTH-1:0] r_load;
  logic [RA_W-1:0]  r_dest [DEPTH];

  logic [FC_W-1:0]  r_flush_cnt;

  logic             w_found_a, w_found_b;
  logic             w_nrdy_a, w_nrdy_b;
  logic [FWD_W-1:0] w_fwd_a_nxt, w_fwd_b_nxt;
  logic             w_accept;

  // Youngest-match search per source operand; first hit in ascending k wins
  always_comb begin
    w_found_a   = 1'b0;
    w_found_b   = 1'b0;
    w_nrdy_a    = 1'b0;
    w_nrdy_b    = 1'b0;
    w_fwd_a_nxt = '0;
    w_fwd_b_nxt = '0;
    for (int unsigned k = 0; k < UD; k++) begin
      if (!w_found_a && r_valid[k] && r_wr[k] && id_use_rs &&
          (id_rs != '0) && (r_dest[k] == id_rs)) begin
        w_found_a   = 1'b1;
        w_nrdy_a    = r_load[k] && (k < ULAT);
        w_fwd_a_nxt = (k + 1 < UD) ? FWD_W'(k + 1) : '0;
      end
      if (!w_found_b && r_valid[k] && r_wr[k] && id_use_rt &&
          (id_rt != '0) && (r_dest[k] == id_rt)) begin
        w_found_b   = 1'b1;
        w_nrdy_b    = r_load[k] && (k < ULAT);
        w_fwd_b_nxt = (k + 1 < UD) ? FWD_W'(k + 1) : '0;
      end
    end
  end

  // Flush dominates stall; accept only when decode is free to advance
  always_comb begin
    flush    = br_taken | (r_flush_cnt != '0);
    stall    = id_valid & ~flush & (w_nrdy_a | w_nrdy_b);
    w_accept = id_valid & ~stall & ~flush;
  end

  // Shift the tag pipeline; entry 0 takes decode fields or a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_wr    <= '0;
      r_load  <= '0;
      for (int unsigned k = 0; k < UD; k++) r_dest[k] <= '0;
    end else begin
      for (int unsigned k = 1; k < UD; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_wr[k]    <= r_wr[k-1];
        r_load[k]  <= r_load[k-1];
        r_dest[k]  <= r_dest[k-1];
      end
      r_valid[0] <= w_accept;
      r_wr[0]    <= w_accept & id_wr;
      r_load[0]  <= w_accept & id_load;
      r_dest[0]  <= id_dest;
    end
  end

  // Forwarding selects for the instruction entering EX; bubbles get 0
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a <= '0;
      fwd_b <= '0;
    end else if (w_accept) begin
      fwd_a <= w_found_a ? w_fwd_a_nxt : '0;
      fwd_b <= w_found_b ? w_fwd_b_nxt : '0;
    end else begin
      fwd_a <= '0;
      fwd_b <= '0;
    end
  end

  // Branch flush window; a new taken branch reloads the counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush_cnt <= '0;
    end else if (br_taken) begin
      r_flush_cnt <= FC_RELOAD;
    end else if (r_flush_cnt != '0) begin
      r_flush_cnt <= r_flush_cnt - FC_W'(1);
    end
  end

  // Saturating stall-cycle performance counter
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_pipeline_hazard_unit;

  localparam int D   = 3;
  localparam int LL  = 1;
  localparam int BRP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs, id_use_rt, id_wr, id_load, br_taken;
  logic [4:0] id_rs, id_rt, id_dest;

  logic        stall, flush, s_stall, s_flush;
  logic [1:0]  fwd_a, fwd_b, s_fwd_a, s_fwd_b;
  logic [15:0] stall_count;
  logic [1:0]  s_stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.RA_W(5), .DEPTH(D), .LOAD_LAT(LL), .BR_PENALTY(BRP),
                         .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_dest(id_dest),
    .id_load(id_load), .br_taken(br_taken), .stall(stall), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count));

  pipeline_hazard_unit #(.RA_W(5), .DEPTH(D), .LOAD_LAT(LL), .BR_PENALTY(BRP),
                         .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_dest(id_dest),
    .id_load(id_load), .br_taken(br_taken), .stall(s_stall), .flush(s_flush),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_count(s_stall_count));

  // ---------------- behavioural model ----------------
  bit       m_v [D];
  bit       m_wr[D];
  bit       m_ld[D];
  bit [4:0] m_dest[D];
  int       m_flush_left = 0;
  int       m_fa = 0, m_fb = 0;
  int       m_cnt = 0, m_cnt_sat = 0;
  bit       m_ok = 0;

  function automatic int youngest(bit [4:0] s, bit u);
    if (!u || s == 0) return -1;
    for (int k = 0; k < D; k++)
      if (m_v[k] && m_wr[k] && m_dest[k] == s) return k;
    return -1;
  endfunction

  function automatic bit waits(int k);
    return (k >= 0) && m_ld[k] && (k < LL);
  endfunction

  function automatic bit m_flush();
    return br_taken || (m_flush_left > 0);
  endfunction

  function automatic bit m_stall();
    return id_valid && !m_flush() &&
           (waits(youngest(id_rs, id_use_rs)) || waits(youngest(id_rt, id_use_rt)));
  endfunction

  function automatic int fsel(int k);
    return (k >= 0 && k <= D - 2) ? k + 1 : 0;
  endfunction

  always @(posedge clk) begin
    bit st, fl, acc;
    int ya, yb;
    st  = m_stall();
    fl  = m_flush();
    acc = id_valid && !st && !fl;
    ya  = youngest(id_rs, id_use_rs);
    yb  = youngest(id_rt, id_use_rt);
    if (reset) begin
      for (int k = 0; k < D; k++) begin m_v[k] = 0; m_wr[k] = 0; m_ld[k] = 0; m_dest[k] = 0; end
      m_flush_left = 0; m_fa = 0; m_fb = 0; m_cnt = 0; m_cnt_sat = 0; m_ok = 1;
    end else begin
      if (st) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_sat < 3) m_cnt_sat++;
      end
      m_fa = acc ? fsel(ya) : 0;
      m_fb = acc ? fsel(yb) : 0;
      for (int k = D - 1; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_wr[k] = m_wr[k-1]; m_ld[k] = m_ld[k-1]; m_dest[k] = m_dest[k-1];
      end
      m_v[0] = acc; m_wr[0] = acc && id_wr; m_ld[0] = acc && id_load; m_dest[0] = id_dest;
      if (br_taken) m_flush_left = BRP - 1;
      else if (m_flush_left > 0) m_flush_left--;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_stall",     32'(stall),         32'(m_stall()));
      chk("m_flush",     32'(flush),         32'(m_flush()));
      chk("m_fwd_a",     32'(fwd_a),         32'(m_fa));
      chk("m_fwd_b",     32'(fwd_b),         32'(m_fb));
      chk("m_count",     32'(stall_count),   32'(m_cnt));
      chk("m_sat_stall", 32'(s_stall),       32'(m_stall()));
      chk("m_sat_count", 32'(s_stall_count), 32'(m_cnt_sat));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_wr = 0; id_dest = 0; id_load = 0; br_taken = 0;
  endtask

  task automatic dec(bit [4:0] rs, bit [4:0] rt, bit urs, bit urt,
                     bit wr, bit [4:0] dest, bit ld);
    id_valid = 1; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wr = wr; id_dest = dest; id_load = ld; br_taken = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic look();
    #6;
  endtask

  task automatic do_reset();
    reset = 1; idle(); nxt(); nxt(); reset = 0;
  endtask

  initial begin
    reset = 1; idle();
    nxt(); nxt();

    // Reset while flushing with a load in flight
    reset = 0;
    dec(0, 0, 0, 0, 1, 5, 1); nxt();
    dec(0, 5, 0, 1, 0, 0, 0); br_taken = 1;
    look(); chk("br_flush", 32'(flush), 1); chk("br_nostall", 32'(stall), 0);
    nxt(); br_taken = 0; reset = 1;
    look(); chk("flush_window", 32'(flush), 1);
    nxt(); reset = 0; idle();
    look(); chk("rst_stall", 32'(stall), 0); chk("rst_flush", 32'(flush), 0);
    chk("rst_fwd_a", 32'(fwd_a), 0); chk("rst_fwd_b", 32'(fwd_b), 0);
    chk("rst_count", 32'(stall_count), 0);

    // Reset asserted mid-stall
    nxt(); dec(0, 0, 0, 0, 1, 5, 1);
    nxt(); dec(0, 5, 0, 1, 0, 0, 0); reset = 1;
    look(); chk("midstall", 32'(stall), 1);
    nxt(); reset = 0;
    look(); chk("post_rst_stall", 32'(stall), 0); chk("post_rst_cnt", 32'(stall_count), 0);

    // ALU dependency, next and second-next consumer
    nxt(); dec(0, 0, 0, 0, 1, 3, 0);
    nxt(); dec(3, 0, 1, 0, 0, 0, 0);
    look(); chk("alu_stall", 32'(stall), 0);
    nxt(); idle();
    look(); chk("alu_fwd1", 32'(fwd_a), 1);
    nxt(); dec(0, 0, 0, 0, 1, 3, 0);
    nxt(); idle();
    nxt(); dec(3, 0, 1, 0, 0, 0, 0);
    look(); chk("alu2_stall", 32'(stall), 0);
    nxt(); idle();
    look(); chk("alu_fwd2", 32'(fwd_a), 2);

    // Load-use on rt
    nxt(); do_reset();
    dec(0, 0, 0, 0, 1, 5, 1);
    nxt(); dec(0, 5, 0, 1, 0, 0, 0);
    look(); chk("lu_stall", 32'(stall), 1);
    nxt();
    look(); chk("lu_release", 32'(stall), 0); chk("lu_bubble_fwd", 32'(fwd_b), 0);
    nxt(); idle();
    look(); chk("lu_fwd_b", 32'(fwd_b), 2); chk("lu_count", 32'(stall_count), 1);

    // Register 0 never matches
    nxt(); dec(0, 0, 0, 0, 1, 0, 1);
    nxt(); dec(0, 0, 1, 1, 0, 0, 0);
    look(); chk("r0_stall", 32'(stall), 0);
    nxt(); idle();
    look(); chk("r0_fwd_a", 32'(fwd_a), 0);

    // Youngest writer wins over an older load
    nxt(); dec(0, 0, 0, 0, 1, 4, 1);
    nxt(); dec(0, 0, 0, 0, 1, 4, 0);
    nxt(); dec(4, 0, 1, 0, 0, 0, 0);
    look(); chk("young_stall", 32'(stall), 0);
    nxt(); idle();
    look(); chk("young_fwd_a", 32'(fwd_a), 1);

    // Taken branch masks a simultaneous load-use hazard
    nxt(); do_reset();
    dec(0, 0, 0, 0, 1, 5, 1);
    nxt(); dec(0, 5, 0, 1, 0, 0, 0); br_taken = 1;
    look(); chk("bf_flush0", 32'(flush), 1); chk("bf_stall0", 32'(stall), 0);
    nxt(); br_taken = 0;
    look(); chk("bf_flush1", 32'(flush), 1); chk("bf_stall1", 32'(stall), 0);
    chk("bf_bubble_fwd", 32'(fwd_b), 0);
    nxt();
    look(); chk("bf_flush2", 32'(flush), 0); chk("bf_stall2", 32'(stall), 0);
    nxt(); idle();
    look(); chk("bf_retire_fwd", 32'(fwd_b), 0); chk("bf_count", 32'(stall_count), 0);

    // Counter saturation on the narrow instance
    nxt(); do_reset();
    for (int i = 0; i < 5; i++) begin
      dec(0, 0, 0, 0, 1, 5, 1);
      nxt(); dec(0, 5, 0, 1, 0, 0, 0);
      nxt();
      look(); chk("sat_count", 32'(s_stall_count), (i < 3) ? i + 1 : 3);
      nxt();
    end
    chk("wide_count", 32'(stall_count), 5);

    // Mixed traffic checked by the model only
    for (int i = 0; i < 80; i++) begin
      dec(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
          1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom));
      id_valid = ($urandom_range(0, 3) != 0);
      br_taken = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 29) == 0);
      nxt();
    end
    reset = 0; idle();
    nxt(); nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
